// File: rtl/scan_serializer.sv
// scan_serializer -- transmit end of the coefficient/state scan link.
// On scan_en it streams all NWORDS words of the x buffer and the w memory out
// over two parallel serial lines. Words go highest address first, LSB-first
// within a word, one bit per scan_clk.
//
// Ports:
//   scan_clk    single clock, rising edge
//   rst_n       synchronous active-low reset
//   scan_en     frame request / enable level from the collector
//   rd_addr     shared read address to the x/w memories
//   rd_data_x/w registered-RAM read data, valid the cycle after rd_addr
//   scan_out_x/w registered serial bits
//   scan_busy   high while shifting or waiting in DONE (freezes LMS updates)
//   scan_done   one-cycle pulse on entry to DONE
module scan_serializer #(
  parameter int DATA_W = 26,
  parameter int NWORDS = 256,
  parameter int AW     = 8
) (
  input  logic              scan_clk,
  input  logic              rst_n,
  input  logic              scan_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [DATA_W-1:0] rd_data_x,
  input  logic [DATA_W-1:0] rd_data_w,
  output logic              scan_out_x,
  output logic              scan_out_w,
  output logic              scan_busy,
  output logic              scan_done
);

  localparam int BW = $clog2(DATA_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [AW-1:0] ADDR_TOP = AW'(NWORDS - 1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [1:0]    WARM_OK  = 2'd2;

  logic [1:0]        state_q,    state_d;
  logic [DATA_W-1:0] shift_x_q,  shift_x_d;
  logic [DATA_W-1:0] shift_w_q,  shift_w_d;
  logic [BW-1:0]     bit_cnt_q,  bit_cnt_d;
  logic [AW-1:0]     word_cnt_q, word_cnt_d;
  logic [1:0]        warm_q,     warm_d;
  logic [AW-1:0]     rd_addr_q,  rd_addr_d;
  logic              out_x_q,    out_x_d;
  logic              out_w_q,    out_w_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;

  always_comb begin
    state_d    = state_q;
    shift_x_d  = shift_x_q;
    shift_w_d  = shift_w_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    warm_d     = warm_q;
    rd_addr_d  = rd_addr_q;
    done_d     = 1'b0;
    out_x_d    = 1'b0;
    out_w_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Parking at the top address lets the RAM output settle on the first
        // word; warm counts the cycles needed before that data is trusted.
        rd_addr_d = ADDR_TOP;
        if (warm_q != WARM_OK) warm_d = warm_q + 2'd1;
        if (scan_en && warm_q == WARM_OK) begin
          shift_x_d  = rd_data_x;
          shift_w_d  = rd_data_w;
          bit_cnt_d  = '0;
          word_cnt_d = ADDR_TOP;
          rd_addr_d  = ADDR_TOP - ADDR_ONE;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_cnt_q == BIT_LAST && word_cnt_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (!scan_en) begin
          state_d   = S_IDLE;
          rd_addr_d = ADDR_TOP;
          warm_d    = 2'd0;
        end else if (bit_cnt_q == BIT_LAST) begin
          // Address was issued a full word earlier, so rd_data already holds
          // the next word. Decrement wraps to the top address after word 0.
          shift_x_d  = rd_data_x;
          shift_w_d  = rd_data_w;
          bit_cnt_d  = '0;
          word_cnt_d = word_cnt_q - ADDR_ONE;
          rd_addr_d  = rd_addr_q - ADDR_ONE;
        end else begin
          shift_x_d = shift_x_q >> 1;
          shift_w_d = shift_w_q >> 1;
          bit_cnt_d = bit_cnt_q + BIT_ONE;
        end
      end
      S_DONE: begin
        // Hold until the collector releases scan_en so it cannot retrigger.
        if (!scan_en) begin
          state_d = S_IDLE;
          warm_d  = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Serial outputs track the post-edge shifter LSB, so the first bit of a
    // word is on the line from its load edge.
    if (state_d == S_SHIFT) begin
      out_x_d = shift_x_d[0];
      out_w_d = shift_w_d[0];
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge scan_clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_x_q  <= '0;
      shift_w_q  <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      warm_q     <= 2'd0;
      rd_addr_q  <= ADDR_TOP;
      out_x_q    <= 1'b0;
      out_w_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_x_q  <= shift_x_d;
      shift_w_q  <= shift_w_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      warm_q     <= warm_d;
      rd_addr_q  <= rd_addr_d;
      out_x_q    <= out_x_d;
      out_w_q    <= out_w_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign scan_out_x = out_x_q;
  assign scan_out_w = out_w_q;
  assign scan_busy  = busy_q;
  assign scan_done  = done_q;

endmodule
